// File: rtl/opcode_encoder_if.sv
// Request/response handshake bundle between the op-request source, the encoder and the decoder.
// The request side carries one-hot ops; the response side carries the encoded 4-bit select.
interface opcode_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_op;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  sel;

    modport master (
        output in_valid, in_op, out_ready,
        input  in_ready, out_valid, sel
    );

    modport slave (
        input  in_valid, in_op, out_ready,
        output in_ready, out_valid, sel
    );
endinterface

// File: rtl/opcode_encoder.sv
// One-hot op request to 4-bit ALU select encoder with a small output FIFO.
// Malformed (not exactly one-hot) requests are consumed, flagged and counted.
module opcode_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    opcode_encoder_if.slave          bus,
    output logic                     err,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic [3:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic [3:0]      sel_q, sel_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0] code;
    logic       one_hot;
    logic       take, push, pop;
    logic [3:0] head_d;

    always_comb begin
        code = 4'b0000;
        case (bus.in_op)
            12'h001: code = 4'b0000;
            12'h002: code = 4'b0001;
            12'h004: code = 4'b0010;
            12'h008: code = 4'b0011;
            12'h010: code = 4'b0100;
            12'h020: code = 4'b0101;
            12'h040: code = 4'b0110;
            12'h080: code = 4'b1000;
            12'h100: code = 4'b1001;
            12'h200: code = 4'b1010;
            12'h400: code = 4'b1011;
            12'h800: code = 4'b1111;
            default: code = 4'b0000;
        endcase
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign one_hot = (|bus.in_op) && ~|(bus.in_op & (bus.in_op - 12'd1));

    assign bus.in_ready  = (level_q != LvlW'(DEPTH));
    assign bus.out_valid = (level_q != '0);
    assign bus.sel       = sel_q;
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign level         = level_q;

    assign take = bus.in_valid && bus.in_ready;
    assign push = take && one_hot;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + (push ? PtrW'(1) : PtrW'(0));
        rd_ptr_d  = rd_ptr_q + (pop ? PtrW'(1) : PtrW'(0));
        level_d   = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
        err_d     = take && !one_hot;
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
        // The incoming code becomes head when the FIFO drains to it this cycle.
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? code : mem_q[rd_ptr_d];
        sel_d  = (level_d != '0) ? head_d : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            sel_q     <= 4'b0000;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= code;
        end
    end
endmodule

// File: tb/tb_opcode_encoder.sv
// Directed bench for opcode_encoder: fill/drain, latency, malformed requests, full-with-pop,
// streaming with wrap, mid-stream reset and counter saturation.
module tb_opcode_encoder;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 8;
    localparam logic [11:0] OP   [12] = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020,
                                          12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800};
    localparam logic [3:0]  CODE [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                          4'h6, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};

    logic clk;
    logic rst_n;
    logic err;
    logic [CNT_W-1:0] err_cnt;
    logic [$clog2(DEPTH):0] level;
    int n_checks;
    int n_fail;

    opcode_encoder_if bus ();

    opcode_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .err     (err),
        .err_cnt (err_cnt),
        .level   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = 12'h000;
        bus.out_ready = 1'b0;
        #12;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel got %h exp 0", bus.sel); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_fill_drain();
        logic [11:0] ops [4];
        logic [3:0]  exp [4];
        ops = '{12'h001, 12'h080, 12'h400, 12'h800};
        exp = '{4'b0000, 4'b1000, 4'b1011, 4'b1111};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op = ops[i];
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d exp 4", level); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b exp 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (bus.sel !== exp[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL drain_sel[%0d] got %h/v%b exp %h/v1", i, bus.sel, bus.out_valid, exp[i]);
            end
            tick();
        end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL drain_level got %0d exp 0", level); end
        n_checks++; if (bus.sel !== 4'b1111) begin n_fail++; $display("FAIL empty_sel_hold got %h exp f", bus.sel); end
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.sel !== 4'b1111) begin
            n_fail++; $display("FAIL empty_pop_ignored got v%b sel %h exp v0 sel f", bus.out_valid, bus.sel);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_latency();
        bus.in_valid = 1'b1;
        bus.in_op = 12'h100;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pre_valid got %b exp 0", bus.out_valid); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.sel !== 4'b1001) begin
            n_fail++; $display("FAIL lat_sel got v%b sel %h exp v1 sel 9", bus.out_valid, bus.sel);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL lat_pop_level got %0d exp 0", level); end
    endtask

    task automatic test_malformed();
        bus.in_valid = 1'b1;
        bus.in_op = 12'h000;
        tick();
        n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin
            n_fail++; $display("FAIL bad_zero got err%b cnt %0d exp err1 cnt 1", err, err_cnt);
        end
        bus.in_op = 12'h003;
        tick();
        n_checks++; if (err !== 1'b1 || err_cnt !== 8'd2 || level !== 3'd0) begin
            n_fail++; $display("FAIL bad_multi got err%b cnt %0d lvl %0d exp err1 cnt 2 lvl 0", err, err_cnt, level);
        end
        bus.in_op = 12'h040;
        tick();
        n_checks++; if (err !== 1'b0 || level !== 3'd1 || bus.sel !== 4'b0110) begin
            n_fail++; $display("FAIL bad_then_good got err%b lvl %0d sel %h exp err0 lvl 1 sel 6", err, level, bus.sel);
        end
        bus.in_valid = 1'b0;
        bus.in_op = 12'h003;
        tick();
        n_checks++; if (err !== 1'b0 || err_cnt !== 8'd2 || level !== 3'd1) begin
            n_fail++; $display("FAIL bad_no_xfer got err%b cnt %0d lvl %0d exp err0 cnt 2 lvl 1", err, err_cnt, level);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [3:0] exp [4];
        exp = '{4'h2, 4'h3, 4'h4, 4'h5};
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op = OP[i];
            tick();
        end
        bus.in_op = OP[5];
        bus.out_ready = 1'b1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", bus.in_ready); end
        tick();
        n_checks++; if (level !== 3'd3 || bus.sel !== 4'h2) begin
            n_fail++; $display("FAIL full_pop got lvl %0d sel %h exp lvl 3 sel 2", level, bus.sel);
        end
        bus.out_ready = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL full_retry_level got %0d exp 4", level); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.sel !== exp[i]) begin n_fail++; $display("FAIL full_order[%0d] got %h exp %h", i, bus.sel, exp[i]); end
            tick();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] q [$];
        q = {};
        for (int i = 7; i <= 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op = OP[i];
            q.push_back(CODE[i]);
            tick();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_op = OP[(i + 9) % 12];
            n_checks++; if (bus.sel !== q[0]) begin n_fail++; $display("FAIL stream_sel[%0d] got %h exp %h", i, bus.sel, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(CODE[(i + 9) % 12]);
            n_checks++; if (level !== 3'd2) begin n_fail++; $display("FAIL stream_level[%0d] got %0d exp 2", i, level); end
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++; if (bus.sel !== q[0]) begin n_fail++; $display("FAIL stream_tail[%0d] got %h exp %h", i, bus.sel, q[0]); end
            tick();
            void'(q.pop_front());
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.in_valid = 1'b1;
        bus.in_op = 12'h0C0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            bus.in_op = OP[i];
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++; if (level !== 3'd3 || err_cnt !== 8'd5) begin
            n_fail++; $display("FAIL pre_reset got lvl %0d cnt %0d exp lvl 3 cnt 5", level, err_cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || level !== 3'd0 || err_cnt !== 8'd0) begin
            n_fail++; $display("FAIL mid_reset got v%b lvl %0d cnt %0d exp v0 lvl 0 cnt 0", bus.out_valid, level, err_cnt);
        end
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = 12'h200;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.sel !== 4'b1010 || level !== 3'd1) begin
            n_fail++; $display("FAIL post_reset got v%b sel %h lvl %0d exp v1 sel a lvl 1", bus.out_valid, bus.sel, level);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        bus.in_valid = 1'b1;
        bus.in_op = 12'h000;
        for (int i = 1; i <= 256; i++) begin
            tick();
            if (i == 254) begin
                n_checks++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d exp 254", err_cnt); end
            end
            if (i == 255) begin
                n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d exp 255", err_cnt); end
            end
        end
        bus.in_valid = 1'b0;
        n_checks++; if (err_cnt !== 8'd255 || err !== 1'b1 || level !== 3'd0) begin
            n_fail++; $display("FAIL sat_hold got cnt %0d err%b lvl %0d exp cnt 255 err1 lvl 0", err_cnt, err, level);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_fill_drain();
        test_latency();
        test_malformed();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/opcode_encoder.md
Name: opcode_encoder

Overview:
- Inverse of the ALU opcode decoder: accepts 12-bit one-hot operation requests and produces the 4-bit `sel` code the decoder consumes.
- Buffers encoded opcodes in a small FIFO with valid/ready handshakes on both sides.
- Checks each request is exactly one-hot; drops and counts malformed requests.
- Sits between the operation-request source (control/sequencer) and the decoder's `sel` input.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request present on `in_op`.
- in_ready  output  1  block can accept a request this cycle.
- in_op  input  12  one-hot operation request.
- out_valid  output  1  `sel` holds a valid encoded opcode.
- out_ready  input  1  downstream consumes `sel` this cycle.
- sel  output  4  encoded opcode at the FIFO head.
- err  output  1  one-cycle pulse: the request accepted last cycle was malformed.
- err_cnt  output  CNT_W  saturating count of malformed requests.
- level  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, `level`=0, `out_valid`=0, `sel`=4'b0000, `err`=0, `err_cnt`=0. `in_ready`=1 once reset is released.
- Encode map, `in_op` bit -> `sel`:
  - b0 AND 0000; b1 OR 0001; b2 NOT 0010; b3 XOR 0011.
  - b4 NAND 0100; b5 NOR 0101; b6 XNOR 0110.
  - b7 ADD 1000; b8 SUB 1001; b9 SHRIGHT 1010; b10 SHLEFT 1011.
  - b11 CLEAR 1111.
- Validity: `in_op` is valid only if exactly one bit is set. All-zero or multi-hot is malformed.
- Input handshake: a transfer occurs when `in_valid` && `in_ready`. `in_ready` = (`level` != DEPTH). It is registered-state derived and does not depend on `out_ready` (no full-bypass).
- Accepted valid request: encoded code is written at the write pointer; it is visible at `sel` no earlier than the next cycle (1-cycle latency when empty).
- Accepted malformed request:
  - Consumed (not retried) and not written to the FIFO.
  - `err`=1 the following cycle.
  - `err_cnt` increments, saturating at 2^CNT_W-1.
  - A non-transfer cycle with malformed `in_op` has no effect.
- Output handshake: `out_valid` = (`level` != 0). `sel` shows the head entry. A pop occurs when `out_valid` && `out_ready`.
- While `out_valid`=1 && `out_ready`=0, `sel` is held stable.
- When empty, `sel` holds its last value. `out_ready` while empty is ignored.
- Simultaneous push and pop: `level` unchanged; both pointers advance.
- Push-only increments `level`; pop-only decrements it.
- Pointers wrap modulo DEPTH.
- Ordering: strict FIFO; malformed requests leave no gap.
- Reset mid-operation: all entries discarded immediately. `out_valid` drops asynchronously; `err_cnt` clears.

Test Plan:
- Reset then push `in_op`=12'h001,12'h080,12'h400,12'h800 with `out_ready`=0 -> `level`=4, `in_ready`=0. Then `out_ready`=1 -> `sel` sequence 0000,1000,1011,1111; `level` returns to 0.
- Empty FIFO, push 12'h100 at cycle N -> `out_valid`=1, `sel`=1001 at cycle N+1.
- Push 12'h000, then 12'h003, then 12'h040 -> `err` pulses twice, `err_cnt`=2, FIFO holds only 0110.
- Full FIFO with `in_valid`=1 and `out_ready`=1 in the same cycle -> no push (`in_ready`=0), one pop, `level`=DEPTH-1. Next cycle the push is accepted.
- Steady stream of 10 alternating pushes/pops at `level`=2 with pointer wrap -> output order matches input order; `level` constant.
- Assert `rst_n`=0 mid-stream with `level`=3 and `err_cnt`=5 -> immediately `out_valid`=0, `level`=0, `err_cnt`=0. After release, the first push appears at `sel` one cycle later.
- Force 256 malformed pushes with CNT_W=8 -> `err_cnt` saturates at 255.
